// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N input streams in, one registered stream out.
// STREAM_MUX_PACKET_LOCK_EN adds the inLast/outLast packet framing signals.
interface stream_mux_rr_if #(
  parameter int nrOfBits   = 8,
  parameter int nrOfInputs = 4,
  parameter int selBits    = 2
);
  logic                           enable;
  logic                           mode;
  logic [selBits-1:0]             sel;
  logic [nrOfInputs*nrOfBits-1:0] muxIn;
  logic [nrOfInputs-1:0]          inValid;
  logic [nrOfInputs-1:0]          inReady;
  logic [nrOfBits-1:0]            muxOut;
  logic                           outValid;
  logic                           outReady;
  logic [selBits-1:0]             outGrant;
`ifdef STREAM_MUX_PACKET_LOCK_EN
  logic [nrOfInputs-1:0]          inLast;
  logic                           outLast;
`endif

  modport master (
`ifdef STREAM_MUX_PACKET_LOCK_EN
    output inLast,
    input  outLast,
`endif
    output enable,
    output mode,
    output sel,
    output muxIn,
    output inValid,
    output outReady,
    input  inReady,
    input  muxOut,
    input  outValid,
    input  outGrant
  );

  modport slave (
`ifdef STREAM_MUX_PACKET_LOCK_EN
    input  inLast,
    output outLast,
`endif
    input  enable,
    input  mode,
    input  sel,
    input  muxIn,
    input  inValid,
    input  outReady,
    output inReady,
    output muxOut,
    output outValid,
    output outGrant
  );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N:1 stream mux, fixed-select or round-robin, with valid/ready.
// Optional packet lock when STREAM_MUX_PACKET_LOCK_EN is defined.
module stream_mux_rr #(
  parameter int nrOfBits   = 8,
  parameter int nrOfInputs = 4,
  parameter int selBits    = 2
) (
  input logic             clock,
  input logic             reset,
  stream_mux_rr_if.slave  bus
);

  logic [nrOfBits-1:0] mux_q;
  logic                vld_q;
  logic [selBits-1:0]  gnt_q;
  logic [selBits-1:0]  rr_ptr;

  logic                space;
  logic                out_xfer;
  logic                in_xfer;

  logic                fix_found;
  logic                rr_found;
  logic [selBits-1:0]  rr_idx;
  logic                has_choice;
  logic [selBits-1:0]  choice;
  logic [nrOfBits-1:0] choice_data;
  logic [nrOfInputs-1:0] ready_vec;

  int                  j;
  logic [selBits-1:0]  j_idx;

`ifdef STREAM_MUX_PACKET_LOCK_EN
  logic                lock_q;
  logic [selBits-1:0]  lock_ch;
  logic                last_q;
  logic                last_bit;
`endif

  assign space    = ~vld_q | bus.outReady;
  assign out_xfer = vld_q & bus.outReady;

  assign fix_found = (int'(bus.sel) < nrOfInputs)
                   && bus.inValid[bus.sel];

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    j        = 0;
    j_idx    = '0;
    for (int k = 1; k <= nrOfInputs; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= nrOfInputs) j = j - nrOfInputs;
      j_idx = j[selBits-1:0];
      if (!rr_found && bus.inValid[j_idx]) begin
        rr_found = 1'b1;
        rr_idx   = j_idx;
      end
    end
  end

  always_comb begin
    has_choice = 1'b0;
    choice     = '0;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    if (lock_q) begin
      has_choice = bus.inValid[lock_ch];
      choice     = lock_ch;
    end else
`endif
    if (bus.mode) begin
      has_choice = rr_found;
      choice     = rr_idx;
    end else begin
      has_choice = fix_found;
      choice     = bus.sel;
    end
  end

  assign in_xfer = has_choice & bus.enable & space;

  always_comb begin
    ready_vec   = '0;
    choice_data = '0;
    for (int i = 0; i < nrOfInputs; i++) begin
      if (choice == selBits'(i)) begin
        choice_data  = bus.muxIn[i*nrOfBits +: nrOfBits];
        ready_vec[i] = in_xfer;
      end
    end
  end

`ifdef STREAM_MUX_PACKET_LOCK_EN
  assign last_bit = bus.inLast[choice];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mux_q  <= '0;
      vld_q  <= 1'b0;
      gnt_q  <= '0;
      rr_ptr <= selBits'(nrOfInputs - 1);
    end else if (in_xfer) begin
      mux_q <= choice_data;
      vld_q <= 1'b1;
      gnt_q <= choice;
`ifdef STREAM_MUX_PACKET_LOCK_EN
      if (bus.mode && last_bit) rr_ptr <= choice;
`else
      if (bus.mode) rr_ptr <= choice;
`endif
    end else if (out_xfer) begin
      vld_q <= 1'b0;
    end
  end

`ifdef STREAM_MUX_PACKET_LOCK_EN
  // Lock holds the channel until its last word is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
      last_q  <= 1'b0;
    end else if (in_xfer) begin
      lock_q  <= ~last_bit;
      lock_ch <= choice;
      last_q  <= last_bit;
    end
  end

  assign bus.outLast = last_q;
`endif

  assign bus.inReady  = ready_vec;
  assign bus.muxOut   = mux_q;
  assign bus.outValid = vld_q;
  assign bus.outGrant = gnt_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: vector table plus reset, range and packet sequences.
// Packet-lock sequence runs only when STREAM_MUX_PACKET_LOCK_EN is defined.
module tb_stream_mux_rr;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  stream_mux_rr_if #(.nrOfBits(8), .nrOfInputs(4), .selBits(2)) bus ();
  stream_mux_rr_if #(.nrOfBits(8), .nrOfInputs(3), .selBits(2)) bus3 ();

  stream_mux_rr #(.nrOfBits(8), .nrOfInputs(4), .selBits(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  stream_mux_rr #(.nrOfBits(8), .nrOfInputs(3), .selBits(2)) u_dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic       md;
    logic [1:0] sl;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic [1:0] e_gnt;
  } vec_t;

  vec_t vt[17];

  initial begin
    vt[0]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vt[1]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vt[2]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vt[3]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vt[4]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vt[5]  = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vt[6]  = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hA2, 2'd2};
    vt[7]  = '{1'b1, 1'b0, 2'd1, 4'b0110, 1'b0, 4'b0000, 1'b1, 8'hA2, 2'd2};
    vt[8]  = '{1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hA2, 2'd2};
    vt[9]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
    vt[10] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
    vt[11] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vt[12] = '{1'b1, 1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vt[13] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vt[14] = '{1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
    vt[15] = '{1'b1, 1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vt[16] = '{1'b1, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};

    bus.enable   = 1'b1;
    bus.mode     = 1'b0;
    bus.sel      = 2'd0;
    bus.muxIn    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.inValid  = 4'b0000;
    bus.outReady = 1'b0;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    bus.inLast   = 4'b1111;
`endif
    bus3.enable   = 1'b1;
    bus3.mode     = 1'b0;
    bus3.sel      = 2'd3;
    bus3.muxIn    = {8'hC2, 8'hC1, 8'hC0};
    bus3.inValid  = 3'b111;
    bus3.outReady = 1'b1;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    bus3.inLast   = 3'b111;
`endif

    #1;
    chk("rst_valid", 32'(bus.outValid), 32'd0);
    chk("rst_data",  32'(bus.muxOut),   32'd0);
    chk("rst_grant", 32'(bus.outGrant), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.enable   = vt[i].en;
      bus.mode     = vt[i].md;
      bus.sel      = vt[i].sl;
      bus.inValid  = vt[i].iv;
      bus.outReady = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(bus.inReady), 32'(vt[i].e_rdy));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_vld", i), 32'(bus.outValid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d_dat", i), 32'(bus.muxOut),   32'(vt[i].e_dat));
      chk($sformatf("v%0d_gnt", i), 32'(bus.outGrant), 32'(vt[i].e_gnt));
    end

    bus.inValid  = 4'b0000;
    bus.outReady = 1'b0;
    @(posedge clock);
    chk("mid_valid_pre", 32'(bus.outValid), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.outValid), 32'd0);
    chk("mid_rst_data",  32'(bus.muxOut),   32'd0);
    chk("mid_rst_grant", 32'(bus.outGrant), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    bus.mode     = 1'b1;
    bus.enable   = 1'b1;
    bus.inValid  = 4'b1111;
    bus.outReady = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(bus.inReady), 32'b0001);
    @(posedge clock);
    #1;
    chk("post_rst_gnt", 32'(bus.outGrant), 32'd0);
    chk("post_rst_dat", 32'(bus.muxOut),   32'hA0);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("oor_rdy%0d", i), 32'(bus3.inReady),  32'd0);
      chk($sformatf("oor_vld%0d", i), 32'(bus3.outValid), 32'd0);
      @(posedge clock);
      #1;
    end
    bus3.sel = 2'd2;
    #1;
    chk("n3_sel2_rdy", 32'(bus3.inReady), 32'b100);
    @(posedge clock);
    #1;
    chk("n3_sel2_vld", 32'(bus3.outValid), 32'd1);
    chk("n3_sel2_dat", 32'(bus3.muxOut),   32'hC2);
    chk("n3_sel2_gnt", 32'(bus3.outGrant), 32'd2);

`ifdef STREAM_MUX_PACKET_LOCK_EN
    bus.inValid = 4'b0000;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    chk("pk_rst_last", 32'(bus.outLast), 32'd0);
    bus.mode     = 1'b1;
    bus.outReady = 1'b1;
    bus.inValid  = 4'b0110;
    bus.muxIn[16 +: 8] = 8'h22;
    for (int w = 0; w < 3; w++) begin
      bus.muxIn[8 +: 8] = 8'(8'h11 + w);
      bus.inLast = (w == 2) ? 4'b0010 : 4'b0000;
      #1;
      chk($sformatf("pk_rdy%0d", w), 32'(bus.inReady), 32'b0010);
      @(posedge clock);
      #1;
      chk($sformatf("pk_gnt%0d", w), 32'(bus.outGrant), 32'd1);
      chk($sformatf("pk_dat%0d", w), 32'(bus.muxOut), 32'(8'h11 + w));
      chk($sformatf("pk_last%0d", w), 32'(bus.outLast),
          (w == 2) ? 32'd1 : 32'd0);
    end
    bus.inLast = 4'b0000;
    #1;
    chk("pk_next_rdy", 32'(bus.inReady), 32'b0100);
    @(posedge clock);
    #1;
    chk("pk_next_gnt", 32'(bus.outGrant), 32'd2);
    chk("pk_next_dat", 32'(bus.muxOut),   32'h22);
    chk("pk_next_last", 32'(bus.outLast), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
